clk_divider_prog: RTL and testbench
===================================

// Module: clk_divider_prog
// PURPOSE
//   Runtime-programmable integer clock divider: divides clk_i by N, where
//   2 <= N <= 2**CNT_WIDTH-1, from a single counter in the clk_i domain.
//   Produces a registered divided clock (near-50% duty) and a one-cycle
//   tick strobe. Ratio changes apply glitch-free at a period boundary.
//   Successor to the fixed divide-by-4 divider; used to test LUT/FF-generated
//   clocks of arbitrary ratio.
// PARAMETERS
//   CNT_WIDTH    8   width of the ratio and the counter
//   DEFAULT_DIV  4   ratio after reset; must satisfy 2 <= DEFAULT_DIV <= 2**CNT_WIDTH-1
// PORTS
//   clk_i      in   1          sole clock; all state updates on posedge
//   rst        in   1          synchronous, active-high reset
//   en_i       in   1          count enable; low = freeze
//   load_i     in   1          1-cycle strobe: request new ratio div_i
//   div_i      in   CNT_WIDTH  requested ratio; 0 or 1 is clamped to 2
//   clk_o      out  1          registered divided clock
//   tick_o     out  1          high for 1 clk_i cycle on each clk_o rising edge
//   div_o      out  CNT_WIDTH  ratio currently in effect
//   pend_o     out  1          a loaded ratio is waiting for the next wrap
// BEHAVIOUR
//   - Reset (rst=1 at posedge):
//     cnt=DEFAULT_DIV-1, div_o=DEFAULT_DIV, pend_o=0, clk_o=0, tick_o=0.
//     Reset dominates en_i/load_i.
//   - Definitions:
//     N = div_o; HI(N) = N - (N>>1), i.e. ceil(N/2); wrap = en_i && cnt==N-1.
//   - Enabled cycle:
//     - cnt_nxt = wrap ? 0 : cnt+1.
//     - On wrap: div_o <= D_new, where D_new is clamp(div_i) if load_i is high
//       this cycle, else the pending value if pend_o=1, else N.
//       pend_o <= 0.
//     - clk_o <= (cnt_nxt < HI(div after this edge)).
//     - tick_o <= (cnt_nxt==0).
//   - Resulting waveform:
//     - clk_o period is exactly N clk_i cycles: high for ceil(N/2) cycles,
//       low for floor(N/2) cycles.
//     - Even N gives 50% duty. Odd N gives high one cycle longer than low.
//     - First enabled edge after reset wraps: clk_o=1 and tick_o=1 at that edge.
//   - Disabled cycle (en_i=0): cnt, clk_o and div_o hold; tick_o <= 0.
//     Loads are still captured.
//   - Load without a wrap this cycle: the pending register <= clamp(div_i)
//     and pend_o <= 1. A later load before the wrap overwrites it (last wins).
//     No change to clk_o/cnt until the wrap.
//   - Load on the wrap cycle: applied at this wrap; pend_o stays 0.
//   - The ratio never changes mid-period, so there are no runt pulses on clk_o.
//   - Rst mid-period: clk_o drops to 0 next edge. The next enabled edge
//     restarts a fresh period at DEFAULT_DIV. The pending ratio is discarded.
//   - Counter is CNT_WIDTH wide and never exceeds N-1; no overflow path.
//   - Latency: load -> new ratio visible on div_o at the first wrap at or after
//     the load; worst case N_old cycles.
// TESTING
//   1. Reset, en_i=1, default N=4 -> clk_o 1,1,0,0 repeating; tick_o every
//      4th cycle; first tick on the first enabled edge.
//   2. load_i with div_i=5 mid-period -> pend_o=1 until the wrap. Then
//      div_o=5 and clk_o 1,1,1,0,0 with period 5; no short pulse at the switch.
//   3. div_i=0 and div_i=1 -> div_o=2, clk_o toggles every cycle.
//      div_i=255 -> period 255, high 128, low 127.
//   4. en_i low for 3 cycles mid-period -> clk_o/cnt frozen, tick_o=0.
//      The period resumes and completes with no lost or extra cycle.
//   5. Two loads (6 then 3) before one wrap -> div_o=3 after the wrap.
//      A load coinciding with the wrap -> applied immediately, pend_o stays 0.
//   6. Assert rst while clk_o=1 with N=7 pending -> the next edge gives
//      clk_o=0, pend_o=0, div_o=4. Counting then restarts at period 4.

Source files
------------

// File: rtl/clk_divider_prog.sv
// clk_divider_prog: runtime-programmable integer clock divider with tick strobe
//   clk_i  : sole clock          rst    : sync active-high reset
//   en_i   : count enable        load_i : strobe to request ratio div_i
//   div_i  : requested ratio (0/1 clamp to 2)
//   clk_o  : registered divided clock (high ceil(N/2), low floor(N/2))
//   tick_o : one-cycle strobe on each clk_o rising edge
//   div_o  : ratio in effect     pend_o : loaded ratio awaiting next wrap
module clk_divider_prog #(
    parameter int CNT_WIDTH   = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic                 clk_i,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic                 load_i,
    input  logic [CNT_WIDTH-1:0] div_i,
    output logic                 clk_o,
    output logic                 tick_o,
    output logic [CNT_WIDTH-1:0] div_o,
    output logic                 pend_o
);
    logic [CNT_WIDTH-1:0] cnt, pend_div, div_clamp, div_wrap, div_new, cnt_nxt, hi_new;
    logic                 wrap;
    always_comb begin
        wrap      = en_i && (cnt == div_o - 1'b1);
        div_clamp = (div_i < CNT_WIDTH'(2)) ? CNT_WIDTH'(2) : div_i;
        // A load on the wrap cycle wins over an older pending ratio
        div_wrap  = load_i ? div_clamp : (pend_o ? pend_div : div_o);
        div_new   = wrap ? div_wrap : div_o;
        cnt_nxt   = wrap ? '0 : cnt + 1'b1;
        hi_new    = div_new - (div_new >> 1);
    end
    always_ff @(posedge clk_i) begin
        if (rst) begin
            cnt      <= CNT_WIDTH'(DEFAULT_DIV - 1);
            div_o    <= CNT_WIDTH'(DEFAULT_DIV);
            pend_div <= '0;
            pend_o   <= 1'b0;
            clk_o    <= 1'b0;
            tick_o   <= 1'b0;
        end else begin
            tick_o <= en_i && (cnt_nxt == '0);
            if (en_i) begin
                cnt   <= cnt_nxt;
                clk_o <= cnt_nxt < hi_new;
            end
            if (wrap) begin
                div_o  <= div_wrap;
                pend_o <= 1'b0;
            end else if (load_i) begin
                pend_div <= div_clamp;
                pend_o   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_clk_divider_prog.sv
// tb_clk_divider_prog: directed self-checking bench for clk_divider_prog
module tb_clk_divider_prog;
    logic       clk_i = 1'b0, rst, en_i, load_i;
    logic [7:0] div_i, div_o;
    logic       clk_o, tick_o, pend_o;
    int         checks = 0, errors = 0;

    clk_divider_prog #(.CNT_WIDTH(8), .DEFAULT_DIV(4)) dut (
        .clk_i(clk_i), .rst(rst), .en_i(en_i), .load_i(load_i), .div_i(div_i),
        .clk_o(clk_o), .tick_o(tick_o), .div_o(div_o), .pend_o(pend_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge, then compare all outputs
    task automatic edge_chk(input string tag, input logic c, input logic t, input int d, input logic p);
        @(posedge clk_i);
        #1;
        check({tag, " clk_o"}, 32'(clk_o), 32'(c));
        check({tag, " tick_o"}, 32'(tick_o), 32'(t));
        check({tag, " div_o"}, 32'(div_o), 32'(d));
        check({tag, " pend_o"}, 32'(pend_o), 32'(p));
    endtask

    // One full period starting at the wrap edge; counter must sit at N-1 on entry
    task automatic run_period(input string tag, input int n);
        for (int i = 0; i < n; i++)
            edge_chk($sformatf("%s p%0d", tag, i), 1'(i < n - n / 2), 1'(i == 0), n, 1'b0);
    endtask

    initial begin
        rst = 1'b1; en_i = 1'b0; load_i = 1'b0; div_i = 8'd0;
        // 1: reset state, then default divide-by-4
        edge_chk("reset", 1'b0, 1'b0, 4, 1'b0);
        rst = 1'b0; en_i = 1'b1;
        run_period("n4a", 4);
        run_period("n4b", 4);
        // 2: load 5 mid-period stays pending until the wrap
        edge_chk("t2 wrap", 1'b1, 1'b1, 4, 1'b0);
        load_i = 1'b1; div_i = 8'd5;
        edge_chk("t2 load", 1'b1, 1'b0, 4, 1'b1);
        load_i = 1'b0;
        edge_chk("t2 c2", 1'b0, 1'b0, 4, 1'b1);
        edge_chk("t2 c3", 1'b0, 1'b0, 4, 1'b1);
        run_period("n5a", 5);
        run_period("n5b", 5);
        // 3: clamps 0 and 1 to 2 (loaded on wrap cycles), then 255
        load_i = 1'b1; div_i = 8'd0;
        edge_chk("t3 d0 w", 1'b1, 1'b1, 2, 1'b0);
        load_i = 1'b0;
        edge_chk("t3 d0 c1", 1'b0, 1'b0, 2, 1'b0);
        run_period("n2", 2);
        load_i = 1'b1; div_i = 8'd1;
        edge_chk("t3 d1 w", 1'b1, 1'b1, 2, 1'b0);
        load_i = 1'b0;
        edge_chk("t3 d1 c1", 1'b0, 1'b0, 2, 1'b0);
        load_i = 1'b1; div_i = 8'd255;
        edge_chk("t3 d255 w", 1'b1, 1'b1, 255, 1'b0);
        load_i = 1'b0;
        for (int i = 1; i < 255; i++)
            edge_chk($sformatf("n255 p%0d", i), 1'(i < 128), 1'b0, 255, 1'b0);
        // 4: freeze during the high phase of N=4
        load_i = 1'b1; div_i = 8'd4;
        edge_chk("t4 w", 1'b1, 1'b1, 4, 1'b0);
        load_i = 1'b0;
        edge_chk("t4 c1", 1'b1, 1'b0, 4, 1'b0);
        en_i = 1'b0;
        for (int i = 0; i < 3; i++)
            edge_chk($sformatf("t4 hold%0d", i), 1'b1, 1'b0, 4, 1'b0);
        en_i = 1'b1;
        edge_chk("t4 c2", 1'b0, 1'b0, 4, 1'b0);
        edge_chk("t4 c3", 1'b0, 1'b0, 4, 1'b0);
        run_period("t4 n4", 4);
        // 5: two loads before one wrap, last wins
        edge_chk("t5 wrap", 1'b1, 1'b1, 4, 1'b0);
        load_i = 1'b1; div_i = 8'd6;
        edge_chk("t5 ld6", 1'b1, 1'b0, 4, 1'b1);
        div_i = 8'd3;
        edge_chk("t5 ld3", 1'b0, 1'b0, 4, 1'b1);
        load_i = 1'b0;
        edge_chk("t5 c3", 1'b0, 1'b0, 4, 1'b1);
        edge_chk("t5 w3", 1'b1, 1'b1, 3, 1'b0);
        edge_chk("t5 c1", 1'b1, 1'b0, 3, 1'b0);
        edge_chk("t5 c2", 1'b0, 1'b0, 3, 1'b0);
        run_period("n3", 3);
        // 6: load 7 while disabled, then reset with clk_o high discards it
        edge_chk("t6 wrap", 1'b1, 1'b1, 3, 1'b0);
        en_i = 1'b0; load_i = 1'b1; div_i = 8'd7;
        edge_chk("t6 ld7 dis", 1'b1, 1'b0, 3, 1'b1);
        en_i = 1'b1; load_i = 1'b0; rst = 1'b1;
        edge_chk("t6 rst", 1'b0, 1'b0, 4, 1'b0);
        rst = 1'b0;
        edge_chk("t6 first", 1'b1, 1'b1, 4, 1'b0);
        edge_chk("t6 c1", 1'b1, 1'b0, 4, 1'b0);
        edge_chk("t6 c2", 1'b0, 1'b0, 4, 1'b0);
        edge_chk("t6 c3", 1'b0, 1'b0, 4, 1'b0);
        run_period("t6 n4", 4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
